// File: rtl/montgomery_pkg.sv
// Shared types and elaboration helpers for the parametrised Montgomery multiplier.
package montgomery_pkg;

  typedef enum logic [1:0] {IDLE, LOOP, SUB, DONE} state_t;

  // One spare bit keeps the counter wide enough to hold WIDTH/K itself.
  function automatic int cnt_width(input int width, input int k);
    return $clog2(width / k) + 1;
  endfunction

  function automatic bit k_legal(input int width, input int k);
    return ((k == 1) || (k == 2) || (k == 4) || (k == 8)) && (width >= k) && ((width % k) == 0);
  endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery step: c_next = (c + a_bit*b + odd*m) >> 1.
module mont_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] c,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] c_next
);

  logic [WIDTH+1:0] sum_b;
  logic [WIDTH+1:0] sum_m;

  // With c < 2M and b < M the intermediate stays below 4M, so WIDTH+2 bits suffice.
  always_comb begin
    sum_b  = c + (a_bit ? {2'b00, b} : '0);
    sum_m  = sum_b + (sum_b[0] ? {2'b00, m} : '0);
    c_next = sum_m >> 1;
  end

endmodule

// File: rtl/montgomery_mul_param.sv
// Radix-2^K Montgomery multiplier: result = A*B*2^-WIDTH mod M, fully reduced.
module montgomery_mul_param
  import montgomery_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int K     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int ITER = WIDTH / K;
  localparam int CW   = cnt_width(WIDTH, K);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  generate
    if (!k_legal(WIDTH, K)) begin : g_bad_k
      $error("montgomery_mul_param: K must be 1, 2, 4 or 8 and divide WIDTH");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH+1:0] c_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] c_chain [K+1];
  logic [WIDTH+1:0] d;
  logic             d_unused;

  assign c_chain[0] = c_q;

  // Step i consumes bit i of a_sh, i.e. the LSB after i single-bit shifts.
  genvar i;
  generate
    for (i = 0; i < K; i++) begin : g_step
      mont_step #(.WIDTH(WIDTH)) u_step (
        .c      (c_chain[i]),
        .a_bit  (a_sh[i]),
        .b      (b_q),
        .m      (m_q),
        .c_next (c_chain[i+1])
      );
    end
  endgenerate

  assign d        = c_q - {2'b00, m_q};
  assign d_unused = d[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_q    <= '0;
      cnt    <= '0;
      a_sh   <= '0;
      b_q    <= '0;
      m_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            c_q   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOOP;
          end
        end
        LOOP: begin
          c_q  <= c_chain[K];
          a_sh <= a_sh >> K;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) state <= SUB;
        end
        SUB: begin
          // A negative difference means C was already below M.
          result <= d[WIDTH+1] ? c_q[WIDTH-1:0] : d[WIDTH-1:0];
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mul_param.sv
// Scoreboard bench for montgomery_mul_param at (8,1), (8,2) and (1024,4).
module tb_montgomery_mul_param;

   typedef struct {
      logic [1023:0] res;
      logic [1023:0] m;
      int            doneEdge;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   nTests = 0;
   int   nFail = 0;
   int   iter [3] = '{8, 4, 256};
   int   busyCnt [3] = '{0, 0, 0};
   exp_t q [3][$];

   logic          rst0, start0, busy0, done0;
   logic [7:0]    ia0, ib0, im0, res0;
   logic          rst1, start1, busy1, done1;
   logic [7:0]    ia1, ib1, im1, res1;
   logic          rst2, start2, busy2, done2;
   logic [1023:0] ia2, ib2, im2, res2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   montgomery_mul_param #(.WIDTH(8), .K(1)) dut0 (
      .clk(clk), .reset(rst0), .start(start0), .in_a(ia0), .in_b(ib0), .in_m(im0),
      .busy(busy0), .done(done0), .result(res0));

   montgomery_mul_param #(.WIDTH(8), .K(2)) dut1 (
      .clk(clk), .reset(rst1), .start(start1), .in_a(ia1), .in_b(ib1), .in_m(im1),
      .busy(busy1), .done(done1), .result(res1));

   montgomery_mul_param #(.WIDTH(1024), .K(4)) dut2 (
      .clk(clk), .reset(rst2), .start(start2), .in_a(ia2), .in_b(ib2), .in_m(im2),
      .busy(busy2), .done(done2), .result(res2));

   // Golden model: (A*B mod M) multiplied by 2^-1 mod M, w times.
   function automatic logic [1023:0] montRef(input logic [1023:0] a, input logic [1023:0] b,
                                             input logic [1023:0] m, input int w);
      logic [2047:0] p;
      logic [1025:0] x;
      p = ({1024'b0, a} * {1024'b0, b}) % {1024'b0, m};
      x = {2'b00, p[1023:0]};
      for (int i = 0; i < w; i++) begin
         if (x[0]) x = x + {2'b00, m};
         x = x >> 1;
      end
      return x[1023:0];
   endfunction

   function automatic logic [1023:0] rand1024();
      logic [1023:0] v;
      for (int j = 0; j < 32; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [1023:0] actual, input logic [1023:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: actual %h..%h required %h..%h", name,
                  actual[1023:960], actual[63:0], expected[1023:960], expected[63:0]);
      end
   endtask

   task automatic setStart(input int sel, input logic v);
      case (sel)
         0: start0 = v;
         1: start1 = v;
         default: start2 = v;
      endcase
   endtask

   // Drive one request at the current negedge; the start edge is the next posedge.
   task automatic applyStimulus(input int sel, input logic [1023:0] a, input logic [1023:0] b,
                                input logic [1023:0] m, input logic [1023:0] expRes,
                                input bit hold, output int t);
      case (sel)
         0: begin ia0 = a[7:0]; ib0 = b[7:0]; im0 = m[7:0]; end
         1: begin ia1 = a[7:0]; ib1 = b[7:0]; im1 = m[7:0]; end
         default: begin ia2 = a; ib2 = b; im2 = m; end
      endcase
      setStart(sel, 1'b1);
      t = cyc + 1;
      // done is visible after edge t+ITER+1, i.e. during cycle t+ITER+2.
      q[sel].push_back('{res: expRes, m: m, doneEdge: t + iter[sel] + 1});
      if (!hold) begin
         @(negedge clk);
         setStart(sel, 1'b0);
      end
   endtask

   task automatic waitIdle(input int sel);
      for (int i = 0; i < 2000 && q[sel].size() != 0; i++) @(negedge clk);
      if (q[sel].size() != 0) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL dut%0d timeout: %0d results still pending, required 0", sel, q[sel].size());
         q[sel].delete();
      end
      @(negedge clk);
   endtask

   task automatic monitorStep(input int sel);
      logic          bz, dn, rs;
      logic [1023:0] r;
      exp_t          e;
      r = '0;
      case (sel)
         0: begin bz = busy0; dn = done0; rs = rst0; r[7:0] = res0; end
         1: begin bz = busy1; dn = done1; rs = rst1; r[7:0] = res1; end
         default: begin bz = busy2; dn = done2; rs = rst2; r = res2; end
      endcase
      if (rs) begin
         busyCnt[sel] = 0;
         return;
      end
      if (bz) busyCnt[sel]++;
      if (dn) begin
         if (q[sel].size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL dut%0d unexpected done at edge %0d: actual 1 required 0", sel, cyc);
         end else begin
            e = q[sel].pop_front();
            checkOutput($sformatf("dut%0d result", sel), r, e.res);
            checkOutput($sformatf("dut%0d done edge", sel), 1024'(cyc), 1024'(e.doneEdge));
            checkOutput($sformatf("dut%0d busy cycles", sel), 1024'(busyCnt[sel]), 1024'(iter[sel] + 1));
            checkOutput($sformatf("dut%0d reduced", sel), {1023'b0, r < e.m}, 1024'd1);
         end
         busyCnt[sel] = 0;
      end
   endtask

   always @(posedge clk) begin
      #1;
      for (int s = 0; s < 3; s++) monitorStep(s);
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int            t, t2;
      logic [1023:0] a, b, m;

      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      ia0 = '0; ib0 = '0; im0 = '0;
      ia1 = '0; ib1 = '0; im1 = '0;
      ia2 = '0; ib2 = '0; im2 = '0;
      repeat (3) @(negedge clk);
      checkOutput("dut0 reset busy", {1023'b0, busy0}, '0);
      checkOutput("dut0 reset done", {1023'b0, done0}, '0);
      checkOutput("dut0 reset result", 1024'(res0), '0);
      checkOutput("dut1 reset busy", {1023'b0, busy1}, '0);
      checkOutput("dut1 reset done", {1023'b0, done1}, '0);
      checkOutput("dut1 reset result", 1024'(res1), '0);
      checkOutput("dut2 reset busy", {1023'b0, busy2}, '0);
      checkOutput("dut2 reset done", {1023'b0, done2}, '0);
      checkOutput("dut2 reset result", res2, '0);
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      @(negedge clk);

      // Directed cases on WIDTH=8, K=1, M=239 (2^-8 mod 239 = 225, 2^8 mod 239 = 17).
      applyStimulus(0, 1, 1, 239, 225, 0, t);     waitIdle(0);
      applyStimulus(0, 0, 200, 239, 0, 0, t);     waitIdle(0);
      applyStimulus(0, 238, 238, 239, 225, 0, t); waitIdle(0);

      // start held high: the second request is taken in the IDLE cycle after DONE.
      applyStimulus(0, 238, 238, 239, 225, 1, t);
      t2 = t + iter[0] + 3;
      q[0].push_back('{res: 1024'd225, m: 1024'd239, doneEdge: t2 + iter[0] + 1});
      while (cyc < t2) @(negedge clk);
      start0 = 1'b0;
      waitIdle(0);

      // start while busy with other operands must be ignored.
      applyStimulus(0, 1, 1, 239, 225, 0, t);
      repeat (3) @(negedge clk);
      ia0 = 8'd17; ib0 = 8'd5; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      waitIdle(0);
      repeat (20) @(negedge clk);

      // Reset in the middle of LOOP aborts the operation.
      applyStimulus(0, 238, 238, 239, 225, 0, t);
      while (cyc < t + 4) @(negedge clk);
      rst0 = 1'b1;
      q[0].delete();
      @(negedge clk);
      checkOutput("dut0 abort busy", {1023'b0, busy0}, '0);
      checkOutput("dut0 abort done", {1023'b0, done0}, '0);
      checkOutput("dut0 abort result", 1024'(res0), '0);
      rst0 = 1'b0;
      @(negedge clk);
      applyStimulus(0, 17, 5, 239, 5, 0, t); waitIdle(0);

      for (int i = 0; i < 20; i++) begin
         a = 1024'($urandom_range(0, 238));
         b = 1024'($urandom_range(0, 238));
         applyStimulus(0, a, b, 239, montRef(a, b, 239, 8), 0, t);
         waitIdle(0);
      end

      // WIDTH=8, K=2.
      applyStimulus(1, 17, 100, 239, 100, 0, t);  waitIdle(1);
      applyStimulus(1, 238, 238, 239, 225, 0, t); waitIdle(1);
      for (int i = 0; i < 20; i++) begin
         m = 1024'($urandom_range(1, 127) * 2 + 1);
         a = 1024'($urandom) % m;
         b = 1024'($urandom) % m;
         applyStimulus(1, a, b, m, montRef(a, b, m, 8), 0, t);
         waitIdle(1);
      end

      // WIDTH=1024, K=4 with random odd moduli.
      for (int i = 0; i < 200; i++) begin
         m = rand1024() >> $urandom_range(0, 16);
         m[0] = 1'b1;
         m[1] = 1'b1;
         if (i % 50 == 0) begin
            a = m - 1;
            b = m - 1;
         end else begin
            a = rand1024() % m;
            b = rand1024() % m;
         end
         applyStimulus(2, a, b, m, montRef(a, b, m, 1024), 0, t);
         waitIdle(2);
      end

      repeat (5) @(negedge clk);
      for (int s = 0; s < 3; s++)
         checkOutput($sformatf("dut%0d pending at end", s), 1024'(q[s].size()), '0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
